// File: rtl/cell_vector_sequencer.sv
// Exhaustive stimulus/response sequencer for an N_IN-input combinational cell:
// sweeps every input vector, samples ZN after SETTLE idle cycles and scores it against TRUTH.
module cell_vector_sequencer #(
    parameter int                      N_IN   = 4,
    parameter int                      SETTLE = 2,
    parameter logic [(1<<N_IN)-1:0]    TRUTH  = 16'hFFFE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [N_IN-1:0]   vec_out,
    input  logic              dut_zn,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic [N_IN-1:0]   first_fail_idx,
    output logic              first_fail_valid,
    output logic              sample_valid,
    output logic [N_IN-1:0]   sample_idx,
    output logic              sample_val
);

    localparam logic [N_IN-1:0] IDX_MAX  = {N_IN{1'b1}};
    localparam logic [3:0]      SETTLE_L = 4'(SETTLE);
    localparam logic [N_IN:0]   ERR_SAT  = {1'b1, {N_IN{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        DONE
    } state_t;

    state_t          state, state_nxt;
    logic [N_IN-1:0] idx;
    logic [3:0]      settle_cnt;
    logic            last_pend;
    logic            launch;
    logic            sample_now;
    logic            mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // last_pend spends one extra APPLY cycle after the final sample so the
    // error count is complete before done and pass rise.
    always_comb begin
        state_nxt  = state;
        launch     = 1'b0;
        sample_now = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    launch    = 1'b1;
                    state_nxt = APPLY;
                end
            end
            APPLY: begin
                if (last_pend) begin
                    state_nxt = DONE;
                end else if (settle_cnt == SETTLE_L) begin
                    sample_now = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // X/Z on the cell output must score as a failure in simulation.
    assign mismatch = (dut_zn !== TRUTH[idx]);

    // Stage p0: vector apply / settle count; stage p1: registered sample and scoring.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx              <= '0;
            settle_cnt       <= '0;
            last_pend        <= 1'b0;
            err_count        <= '0;
            first_fail_idx   <= '0;
            first_fail_valid <= 1'b0;
            sample_valid     <= 1'b0;
            sample_idx       <= '0;
            sample_val       <= 1'b0;
        end else begin
            sample_valid <= sample_now;
            if (launch) begin
                idx              <= '0;
                settle_cnt       <= '0;
                last_pend        <= 1'b0;
                err_count        <= '0;
                first_fail_idx   <= '0;
                first_fail_valid <= 1'b0;
            end else if (sample_now) begin
                sample_idx <= idx;
                sample_val <= dut_zn;
                if (mismatch) begin
                    if (err_count != ERR_SAT) begin
                        err_count <= err_count + 1'b1;
                    end
                    if (!first_fail_valid) begin
                        first_fail_valid <= 1'b1;
                        first_fail_idx   <= idx;
                    end
                end
                if (idx == IDX_MAX) begin
                    last_pend <= 1'b1;
                end else begin
                    idx        <= idx + 1'b1;
                    settle_cnt <= '0;
                end
            end else if ((state == APPLY) && !last_pend) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
        end
    end

    assign vec_out = idx;
    assign busy    = (state == APPLY);
    assign done    = (state == DONE);
    assign pass    = (state == DONE) && (err_count == '0);

endmodule

// File: tb/tb_cell_vector_sequencer.sv
// Bench for cell_vector_sequencer: two instances (default OR4 table, and NOR4 table with SETTLE=0)
// checked every cycle against a sweep-timeline model plus hand-computed literal results.
module tb_cell_vector_sequencer;

    localparam int NV = 16;
    localparam int M_OR = 0, M_NOR = 1, M_TIE0 = 2, M_TIE1 = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start0 = 1'b0, start1 = 1'b0;
    int   mode0 = M_OR, mode1 = M_NOR;

    logic [3:0] vec0, vec1, ffi0, ffi1, sidx0, sidx1;
    logic [4:0] err0, err1;
    logic       zn0, zn1, busy0, busy1, done0, done1, pass0, pass1;
    logic       ffv0, ffv1, sv0, sv1, sval0, sval1;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    function automatic logic zf(input int m, input int i);
        case (m)
            M_OR:    return (i != 0);
            M_NOR:   return (i == 0);
            M_TIE0:  return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    assign zn0 = zf(mode0, int'(vec0));
    assign zn1 = zf(mode1, int'(vec1));

    cell_vector_sequencer u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .vec_out(vec0), .dut_zn(zn0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_fail_idx(ffi0), .first_fail_valid(ffv0), .sample_valid(sv0),
        .sample_idx(sidx0), .sample_val(sval0)
    );

    cell_vector_sequencer #(.N_IN(4), .SETTLE(0), .TRUTH(16'h0001)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .vec_out(vec1), .dut_zn(zn1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail_idx(ffi1), .first_fail_valid(ffv1), .sample_valid(sv1),
        .sample_idx(sidx1), .sample_val(sval1)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Model: each sweep is a timeline of edges e since the launch edge.
    int         ph[2]  = '{0, 0};     // 0 idle, 1 running, 2 done
    int         e[2]   = '{0, 0};
    int         lm[2]  = '{0, 0};
    int         per[2] = '{3, 1};
    logic [15:0] tt[2] = '{16'hFFFE, 16'h0001};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph[0] = 0; ph[1] = 0; e[0] = 0; e[1] = 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (ph[k] == 1) begin
                    e[k]++;
                    if (e[k] == NV * per[k] + 1) ph[k] = 2;
                end else if ((k == 0) ? start0 : start1) begin
                    ph[k] = 1;
                    e[k]  = 0;
                    lm[k] = (k == 0) ? mode0 : mode1;
                end
            end
        end
    end

    task automatic cmp_inst(input int k, input logic [3:0] v, input logic b, input logic d,
                            input logic p, input logic [4:0] ec, input logic [3:0] ffi,
                            input logic ffv, input logic sv, input logic [3:0] sidx,
                            input logic sval);
        int ns, xv, xsv, xsidx, xerr, xffi, xffv, xb, xd, xp;
        string pf;
        pf = $sformatf("u%0d", k);
        ns = 0; xv = 0; xsv = 0; xsidx = 0; xb = 0; xd = 0;
        if (ph[k] == 1) begin
            ns    = e[k] / per[k];
            xv    = (e[k] < NV * per[k]) ? e[k] / per[k] : NV - 1;
            xsv   = (e[k] > 0 && e[k] % per[k] == 0) ? 1 : 0;
            xsidx = e[k] / per[k] - 1;
            xb    = 1;
        end else if (ph[k] == 2) begin
            ns = NV; xv = NV - 1; xd = 1;
        end
        xerr = 0; xffi = 0; xffv = 0;
        for (int i = 0; i < ns; i++) begin
            if (zf(lm[k], i) != tt[k][i]) begin
                if (xffv == 0) xffi = i;
                xffv = 1;
                xerr++;
            end
        end
        xp = (xd == 1 && xerr == 0) ? 1 : 0;
        chk({pf, ".vec_out"}, int'(v), xv);
        chk({pf, ".busy"}, int'(b), xb);
        chk({pf, ".done"}, int'(d), xd);
        chk({pf, ".pass"}, int'(p), xp);
        chk({pf, ".err_count"}, int'(ec), xerr);
        chk({pf, ".first_fail_valid"}, int'(ffv), xffv);
        if (xffv == 1) chk({pf, ".first_fail_idx"}, int'(ffi), xffi);
        chk({pf, ".sample_valid"}, int'(sv), xsv);
        if (xsv == 1) begin
            chk({pf, ".sample_idx"}, int'(sidx), xsidx);
            chk({pf, ".sample_val"}, int'(sval), int'(zf(lm[k], xsidx)));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            cmp_inst(0, vec0, busy0, done0, pass0, err0, ffi0, ffv0, sv0, sidx0, sval0);
            cmp_inst(1, vec1, busy1, done1, pass1, err1, ffi1, ffv1, sv1, sidx1, sval1);
        end
    end

    // Launch a sweep on instance k and count edges from the start edge until done.
    task automatic sweep(input int k, input bit hold, input bit poke,
                         output int len, output int npulse, output int nzero);
        len = 0; npulse = 0; nzero = 0;
        @(negedge clk);
        if (k == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        if (k == 0) start0 = hold; else start1 = hold;
        while (len < 200) begin
            @(posedge clk);
            #1;
            len++;
            if (poke && k == 0) start0 = (len == 10 || len == 11);
            if ((k == 0) ? sv0 : sv1) begin
                npulse++;
                if (((k == 0) ? sval0 : sval1) == 1'b0) nzero++;
            end
            if ((k == 0) ? done0 : done1) break;
        end
        if (len >= 200) chk("sweep_timeout", len, -1);
    endtask

    int len, np, nz, guard;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst.vec_out", int'(vec0), 0);
        chk("rst.busy", int'(busy0), 0);
        chk("rst.done", int'(done0), 0);
        chk("rst.pass", int'(pass0), 0);
        chk("rst.err_count", int'(err0), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: correct OR4
        sweep(0, 1'b0, 1'b0, len, np, nz);
        chk("or4.len", len, 49);
        chk("or4.pass", int'(pass0), 1);
        chk("or4.err", int'(err0), 0);
        chk("or4.ffv", int'(ffv0), 0);
        chk("or4.pulses", np, 16);
        chk("or4.zero_samples", nz, 1);

        // 2: output stuck at 0
        mode0 = M_TIE0;
        sweep(0, 1'b0, 1'b0, len, np, nz);
        chk("tie0.err", int'(err0), 15);
        chk("tie0.ffi", int'(ffi0), 1);
        chk("tie0.pass", int'(pass0), 0);

        // 3: output stuck at 1
        mode0 = M_TIE1;
        sweep(0, 1'b0, 1'b0, len, np, nz);
        chk("tie1.err", int'(err0), 1);
        chk("tie1.ffi", int'(ffi0), 0);
        chk("tie1.pass", int'(pass0), 0);

        // 4: reset mid-sweep at vector 7
        mode0 = M_TIE0;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        guard = 0;
        while (vec0 != 4'd7 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("midrst.reach7", int'(vec0), 7);
        chk("midrst.err_before", int'(err0), 6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.busy", int'(busy0), 0);
        chk("midrst.vec_out", int'(vec0), 0);
        chk("midrst.err", int'(err0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        mode0 = M_OR;
        sweep(0, 1'b0, 1'b0, len, np, nz);
        chk("afterrst.len", len, 49);
        chk("afterrst.pass", int'(pass0), 1);

        // 5: start ignored while busy; then start held through DONE
        sweep(0, 1'b0, 1'b1, len, np, nz);
        chk("poke.len", len, 49);
        mode0 = M_TIE0;
        sweep(0, 1'b1, 1'b0, len, np, nz);
        chk("hold.err_first", int'(err0), 15);
        @(posedge clk);
        #1;
        chk("hold.restart_busy", int'(busy0), 1);
        chk("hold.restart_err", int'(err0), 0);
        chk("hold.restart_vec", int'(vec0), 0);
        start0 = 1'b0;
        guard = 0;
        while (!done0 && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("hold.second_done", int'(done0), 1);
        chk("hold.second_err", int'(err0), 15);

        // 6: NOR4 table, SETTLE=0
        sweep(1, 1'b0, 1'b0, len, np, nz);
        chk("nor4.len", len, 17);
        chk("nor4.pass", int'(pass1), 1);
        chk("nor4.pulses", np, 16);
        mode1 = M_OR;
        sweep(1, 1'b0, 1'b0, len, np, nz);
        chk("nor4_or.err", int'(err1), 16);
        chk("nor4_or.ffi", int'(ffi1), 0);
        chk("nor4_or.pass", int'(pass1), 0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cell_vector_sequencer.md
Name: cell_vector_sequencer

Overview:
- Self-checking exhaustive stimulus and response stage for combinational standard cells, e.g. OR4_X1/NOR4_X1.
- Sits directly upstream of the cell under test and drives all 2^N_IN input combinations into it.
- Directly consumes the cell's ZN output and compares each sample against a parameterised truth table.
- Reports error count, first failing vector, and pass/fail; replaces hand-written per-vector delay/display sequences.

Parameters:
- N_IN, 4, number of cell inputs (1..6); vec_out MSB drives A1, LSB drives A(N_IN).
- SETTLE, 2, idle cycles between applying a vector and sampling dut_zn (0..15).
- TRUTH, 16'hFFFE, expected output table; bit i = expected ZN for vector index i; width 2^N_IN; default = OR4.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  level; sampled only in IDLE or DONE.
- vec_out  output  N_IN  stimulus to cell inputs, A1 = MSB.
- dut_zn  input  1  cell output under test.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from end of sweep until next start or reset.
- pass  output  1  valid while done: 1 iff err_count == 0.
- err_count  output  N_IN+1  number of mismatching vectors.
- first_fail_idx  output  N_IN  index of first mismatch.
- first_fail_valid  output  1  at least one mismatch recorded this sweep.
- sample_valid  output  1  one-cycle pulse per compared vector.
- sample_idx  output  N_IN  vector index of the current sample_valid pulse.
- sample_val  output  1  dut_zn value captured with sample_valid.

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0, including vec_out, counters, pass and done.
- States: IDLE, APPLY, DONE.
- IDLE, start=1 at edge t:
  - idx=0, settle_cnt=0; err_count, first_fail_* cleared.
  - vec_out=0 and busy=1 from t+1.
- APPLY: vec_out = idx, held stable for SETTLE+1 cycles.
  - settle_cnt increments each edge until it equals SETTLE.
  - On that edge, dut_zn is sampled and compared with TRUTH[idx].
  - sample_valid=1, sample_idx=idx, sample_val=dut_zn, registered, visible the following cycle.
- Mismatch handling:
  - err_count increments, saturating at 2^N_IN.
  - If first_fail_valid=0: set it to 1 and latch first_fail_idx=idx.
- Simulation only: dut_zn of X or Z counts as a mismatch (case inequality), and sample_val shows the raw value.
- Index advance: idx < 2^N_IN-1 → idx+1, settle_cnt=0, new vec_out on the next cycle.
- Index wrap: idx == 2^N_IN-1 → DONE; busy=0, done=1, pass=(err_count_final==0), and vec_out holds the last vector.
- Sweep length: start edge to done high = 2^N_IN*(SETTLE+1)+1 cycles; 49 at defaults.
- SETTLE=0: each vector is applied and sampled in the same cycle, which requires a purely combinational DUT path.
- DONE:
  - Holds all results until start=1.
  - start=1 clears the results and behaves as in IDLE.
  - start held continuously produces back-to-back sweeps with one DONE cycle between them.
- start is ignored while busy.
- rst_n low mid-sweep immediately aborts the sweep and returns all outputs to reset values; no partial results are retained.
- Count semantics: err_count counts mismatching vectors, not cycles. A vector is compared exactly once, and dut_zn glitches during the settle cycles are ignored.

Test Plan:
1. Correct OR4 connected, defaults, start pulse at cycle 3:
   - vec_out steps 0..15, each held 3 cycles.
   - done=1 exactly 49 cycles after the start edge.
   - pass=1, err_count=0, first_fail_valid=0.
   - 16 sample_valid pulses with sample_val=0 only for idx 0.
2. dut_zn tied 0 → err_count=15, first_fail_idx=1, pass=0.
3. dut_zn tied 1 → err_count=1, first_fail_idx=0, pass=0.
4. Reset mid-run: rst_n low while vec_out=7 → same-cycle clear of busy, vec_out and err_count to 0. Release, then start → sweep restarts at vec_out=0 with full 49-cycle length.
5. start pulsed while busy is ignored (sweep length unchanged). start held high through DONE → second sweep begins after one DONE cycle with cleared counters.
6. NOR4 DUT with TRUTH=16'h0001, SETTLE=0 → done 17 cycles after start, pass=1. Same settings with OR4 connected → err_count=16.
